// File: rtl/seq_mul_acc.sv
// Iterative unsigned multiply-accumulate: P = A*B + C.
// One multiplier bit is consumed per clock (radix-2 shift-add), so every
// operation takes exactly WIDTH cycles regardless of operand values.
module seq_mul_acc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   C,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]     p_q, p_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     acc_sum;

    // Partial-product add for the current multiplier bit; cannot overflow PW bits.
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state and datapath updates; everything holds unless a state says otherwise.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // DONE accepts start just like IDLE, giving back-to-back operation.
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = {{WIDTH{1'b0}}, C};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = StRun;
                end else begin
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            StRun: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    p_d     = acc_sum;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_mul_acc.sv
// Self-checking bench for seq_mul_acc (WIDTH=8): a cycle-level behavioural
// model plus literal expectations for the directed cases.
module tb_seq_mul_acc;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   A, B, C;
    logic [2*W-1:0] P;
    logic           busy;
    logic           done;

    int n_vec;
    int n_err;
    bit check_en;

    seq_mul_acc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: an accepted request produces A*B+C exactly W edges later.
    logic [2*W-1:0] m_p, m_pend;
    logic           m_busy, m_done;
    int             m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p    <= '0;
            m_pend <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_p    <= m_pend;
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            if (start) begin
                m_pend <= {8'b0, A} * {8'b0, B} + {8'b0, C};
                m_rem  <= W;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("model_P", 32'(P), 32'(m_p));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    // Count negedges until done is seen; lat==W means done after edge k+W.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) return;
            lat++;
        end
        check("done_timeout", 32'(lat), 32'(W));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [2*W-1:0] exp_p, input string name);
        int lat;
        @(posedge clk); #2;
        A = a; B = b; C = c; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(W));
        check({name, "_P"}, 32'(P), 32'(exp_p));
    endtask

    initial begin
        int lat, cnt;
        logic [W-1:0] ra, rb, rq, rr;
        n_vec = 0; n_err = 0; check_en = 1'b0;
        start = 1'b0; A = '0; B = '0; C = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_P", 32'(P), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check_en = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;

        // Directed products with hand-computed results.
        run_op(8'd13, 8'd11, 8'd7, 16'h0096, "t1");
        run_op(8'd255, 8'd255, 8'd255, 16'hFF00, "t2_ones");
        run_op(8'd0, 8'd200, 8'd9, 16'h0009, "t2_a0");
        run_op(8'd77, 8'd0, 8'd0, 16'h0000, "t2_b0");

        // Start held high: back-to-back results accepted in DONE.
        @(posedge clk); #2;
        A = 8'd3; B = 8'd5; C = 8'd1; start = 1'b1;
        wait_done(lat);
        check("t3_first_P", 32'(P), 32'h10);
        wait_done(lat);
        check("t3_interval", 32'(lat + 1), 32'(W + 1));
        check("t3_second_P", 32'(P), 32'h10);
        for (int i = 0; i < 4; i++) @(negedge clk);
        A = 8'd4;
        wait_done(lat);
        check("t3_inflight_P", 32'(P), 32'h10);
        wait_done(lat);
        check("t3_newA_P", 32'(P), 32'd21);
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);

        // Start pulses during RUN are ignored.
        @(posedge clk); #2;
        A = 8'd9; B = 8'd9; C = 8'd0; start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #2;
            start = (i >= 1 && i <= 6);
            @(negedge clk);
            if (done) cnt++;
        end
        check("t4_done_count", 32'(cnt), 32'd1);
        check("t4_P", 32'(P), 32'd81);

        // Asynchronous reset mid-run.
        @(posedge clk); #2;
        A = 8'd200; B = 8'd100; C = 8'd3; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_P", 32'(P), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_done", 32'(done), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("t5_no_done", 32'(cnt), 32'd0);
        run_op(8'd6, 8'd7, 8'd2, 16'h002C, "t5_fresh");

        // Divider round trip: q*b + r rebuilds the dividend.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(255, 0));
            rb = W'($urandom_range(255, 1));
            rq = ra / rb;
            rr = ra % rb;
            run_op(rq, rb, rr, {8'b0, ra}, "t6_roundtrip");
        end

        // Random MACs against the model's own arithmetic.
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rq = W'($urandom);
            run_op(ra, rb, rq, {8'b0, ra} * {8'b0, rb} + {8'b0, rq}, "rand_mac");
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mul_acc.md
Name: seq_mul_acc

Overview:
- Iterative unsigned multiply-accumulate: computes P = A*B + C using radix-2 shift-add, one multiplier bit per clock.
- It is the inverse of the team's combinational divider: feeding it a quotient, divisor and remainder rebuilds the dividend.
- It sits in the mini-processor ALU as the multi-cycle MUL/MAC unit, driven by a start/busy/done handshake from the control FSM.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32). The product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  multiplicand (unsigned)
- B  input  WIDTH  multiplier (unsigned)
- C  input  WIDTH  addend (unsigned), zero-extended to 2*WIDTH
- P  output  2*WIDTH  registered result A*B+C
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: P has just been updated

Behaviour:
- Interface: one clock domain, clk. Reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE, P=0, busy=0, done=0.
  - Internal accumulator, operand registers and counter cleared.
  - Any in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch A into mcand (2*WIDTH, zero-extended), B into mplier, and zero-extended C into acc; cnt=0; go to RUN; busy=1 from that edge.
  - start=0: stay in IDLE.
- RUN, each edge:
  - If mplier[0]=1: acc = acc + mcand, modulo 2^(2*WIDTH). Overflow is impossible, since the maximum is (2^W-1)^2 + (2^W-1) < 2^(2W).
  - Then mcand shifts left 1, mplier shifts right 1, cnt increments.
  - start is ignored throughout RUN; operand inputs are not re-sampled.
- RUN exit, on the edge where cnt==WIDTH-1 (WIDTH iterations done):
  - P = final acc (including that edge's add).
  - State goes to DONE; done=1, busy=0.
- Latency: start sampled at edge k gives done=1 and the new P valid during the cycle after edge k+WIDTH. For WIDTH=8 that is 8 cycles after acceptance. Throughput is one result per WIDTH+1 cycles.
- DONE (exactly one cycle):
  - done deasserts at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back; state goes to RUN, busy=1). Otherwise go to IDLE.
- P holding rule:
  - P changes only on completion or reset.
  - During RUN, P keeps the previous result.
  - P holds indefinitely in IDLE.
- No early termination: a B of 0 or small values still takes WIDTH cycles.
- No combinational path from inputs to outputs; busy and done are registered.
- Boundaries:
  - B=0 gives P=C.
  - A=0 gives P=C.
  - All-ones operands give P=2^(2W)-2^W.

Test Plan:
1. Reset, then A=13, B=11, C=7, start pulsed at edge 0 -> busy=1 for cycles 1..8; done=1 for one cycle after edge 8; P=0x0096 (150). P reads 0x0000 before that.
2. A=255, B=255, C=255 -> P=0xFF00 (65280). Then A=0, B=200, C=9 -> P=0x0009. Then A=77, B=0, C=0 -> P=0x0000; latency is still 8 cycles each time.
3. Start held high continuously with A=3, B=5, C=1 -> results every 9 cycles (accepted in DONE); P=0x0010 each time. Changing A to 4 at cycle 4 has no effect on the in-flight result.
4. Pulse start again at cycles 2..7 of RUN -> ignored: exactly one done pulse and one result.
5. Assert rst_n=0 asynchronously mid-RUN (cycle 4, off the clock edge) -> P, busy and done go to 0 immediately. After release, no done pulse occurs until a new start is given. A fresh 6*7+2 then gives P=0x002C.
6. Divider round-trip: for random A and nonzero B, feed quotient, B and remainder from the divider (WIDTH=8) into this block -> P equals the original A for 1000 random vectors.
